// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, widths and pointer-wrap helper for the UART TX arbiter
package uart_arb_pkg;
  localparam int UART_ARB_MAX_REQ = 4;
  localparam int UART_ARB_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} arb_state_t;
  function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
    return (id + 32'd1 == n) ? 32'd0 : id + 32'd1;
  endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: picks the first valid requester at or after rr_ptr, searching cyclically
module rr_select #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any_valid,
  output logic [$clog2(NUM_REQ)-1:0] winner_id
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign any_valid = |req_valid;
  // Rotating within NUM_REQ bits keeps the wrap correct for non-power-of-two counts
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    winner_id = (sum >= (IW + 1)'(NUM_REQ)) ? IW'(sum - (IW + 1)'(NUM_REQ)) : IW'(sum);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one UART TX; UART_ARB_TIMEOUT_EN adds stalled-grant release
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 4800
) (
  input  logic                              clk_48mhz,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*UART_ARB_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [UART_ARB_DATA_W-1:0]        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic                              grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              timeout
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, state_d;
  logic [IW-1:0] rr_ptr, winner_id;
  logic any_valid, last_q, accept, expire, release_grant;

  rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .req_valid(req_valid),
    .rr_ptr(rr_ptr),
    .any_valid(any_valid),
    .winner_id(winner_id)
  );

  assign accept = state == LOAD && req_valid[grant_id];
  assign release_grant = (state == WAIT_DONE && !tx_busy && last_q) || expire;
  assign req_ready = (state == LOAD) ? req_valid & (NUM_REQ'(1) << grant_id) : '0;
  assign tx_start = state == START;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = state == LOAD && !accept && cnt == CW'(TIMEOUT_CYCLES);
  assign timeout = expire;
  // Outside LOAD the count sits at zero, so every LOAD entry starts fresh
  always_ff @(posedge clk_48mhz or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (state == LOAD && !accept && !expire) ? cnt + 1'b1 : '0;
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_48mhz or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = any_valid ? LOAD : IDLE;
      LOAD:      state_d = accept ? START : expire ? IDLE : LOAD;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : last_q ? IDLE : LOAD;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset)
    if (!reset) begin
      grant_id <= '0;
      grant_valid <= 1'b0;
      rr_ptr <= '0;
      tx_data <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant_id <= winner_id;
        grant_valid <= 1'b1;
      end
      if (accept) begin
        tx_data <= req_data[grant_id*UART_ARB_DATA_W +: UART_ARB_DATA_W];
        last_q <= req_last[grant_id];
      end
      if (release_grant) begin
        rr_ptr <= IW'(wrap_inc(32'(grant_id), NUM_REQ));
        grant_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a message-level round-robin model
module tb_uart_tx_arbiter;
  localparam int N = 3;
  logic clk_48mhz = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*8-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, grant_valid, timeout;
  logic tx_busy = 1'b0;
  logic [1:0] grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  logic [7:0] bq[N][$];
  logic lq[N][$];
  int dp[N];
  bit stall[N];
  logic [9:0] exp_q[$];
  logic [1:0] gid_log[$];
  int start_cyc[$];
  int checks = 0, passed = 0, cyc = 0, s_cyc = 0, bcnt = 0, busy_len = 0, to_cnt = 0, model_ptr = 0;
  bit gap_en = 0;
  logic s_start, s_gv, s_to;
  logic [N-1:0] s_rdy;
  logic [1:0] s_gid;
  logic [7:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (dp[i] < bq[i].size()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    bq[r].push_back(d);
    lq[r].push_back(l);
  endtask

  task automatic add_msg(input int r, input int len);
    for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
  endtask

  // Whole messages are granted to the first requester with work at or after the pointer
  task automatic build_exp();
    int rp[N];
    int w;
    for (int i = 0; i < N; i++) rp[i] = dp[i];
    forever begin
      w = -1;
      for (int k = N - 1; k >= 0; k--)
        if (rp[(model_ptr + k) % N] < bq[(model_ptr + k) % N].size()) w = (model_ptr + k) % N;
      if (w < 0) break;
      do begin
        exp_q.push_back({2'(w), bq[w][rp[w]]});
        rp[w]++;
      end while (rp[w] < bq[w].size() && !lq[w][rp[w]-1]);
      model_ptr = (w + 1) % N;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit has, mid, gap;
      has = dp[i] < bq[i].size();
      mid = has && dp[i] > 0 && !lq[i][dp[i]-1];
      gap = gap_en && mid && $urandom_range(0, 3) == 0;
      req_valid[i] = has && !gap && !stall[i];
      req_data[i*8 +: 8] = has ? bq[i][dp[i]] : 8'h00;
      req_last[i] = has ? lq[i][dp[i]] : 1'b0;
    end
  endtask

  task automatic step();
    logic [9:0] e;
    @(negedge clk_48mhz);
    s_rdy = req_ready; s_start = tx_start; s_gv = grant_valid; s_gid = grant_id;
    s_data = tx_data; s_to = timeout; s_cyc = cyc;
    chk("ready_owner", 32'(s_rdy & ~(req_valid & (s_gv ? (3'b001 << s_gid) : 3'b000))), 0);
    if (s_to) to_cnt++;
    if (s_start) begin
      start_cyc.push_back(cyc);
      gid_log.push_back(s_gid);
      chk("start_uart_idle", tx_busy, 0);
      chk("start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", s_data, e[7:0]);
        chk("tx_owner", {s_gv, s_gid}, {1'b1, e[9:8]});
      end
    end
    @(posedge clk_48mhz);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (s_rdy[i] && req_valid[i]) dp[i]++;
    if (s_start) bcnt = (busy_len != 0) ? busy_len : int'($urandom_range(1, 6));
    else if (bcnt > 0) bcnt--;
    tx_busy = bcnt != 0;
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((pending() || exp_q.size() != 0 || grant_valid || tx_busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      bq[i].delete(); lq[i].delete(); dp[i] = 0; stall[i] = 0;
    end
    exp_q.delete(); gid_log.delete(); start_cyc.delete();
    req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; bcnt = 0;
    model_ptr = 0; gap_en = 0; busy_len = 0;
    repeat (2) @(posedge clk_48mhz);
    #1 reset = 1'b1;
    cyc = 0; to_cnt = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] want[4];
    int n, t;
    // Reset values with requests already pending
    req_valid = '1;
    #1 reset = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout", timeout, 0);
    do_reset();

    // Single two-byte message, fixed 10-cycle frames
    add_byte(0, 8'h48, 1'b0); add_byte(0, 8'h69, 1'b1);
    build_exp(); busy_len = 10; drive();
    step(); chk("lat_c0_gv", s_gv, 0);
    step(); chk("lat_c1_gv", s_gv, 1); chk("lat_c1_ready", s_rdy, 3'b001);
    step(); chk("lat_c2_start", s_start, 1); chk("lat_c2_data", s_data, 8'h48);
    run(200);
    chk("single_starts", start_cyc.size(), 2);
    chk("single_second_start", start_cyc.size() > 1 ? start_cyc[1] : -1, 15);
    chk("single_released", grant_valid, 0);

    // Contention: two 2-byte messages, no interleaving
    do_reset();
    add_msg(0, 2); add_msg(1, 2);
    build_exp(); busy_len = 4; drive();
    run(300);
    want = '{2'd0, 2'd0, 2'd1, 2'd1};
    for (int k = 0; k < 4; k++) chk($sformatf("contend_gid%0d", k), gid_log[k], want[k]);
    chk("contend_empty", exp_q.size(), 0);

    // Fairness: repeated single-byte messages alternate
    do_reset();
    add_msg(0, 1); add_msg(0, 1); add_msg(1, 1); add_msg(1, 1);
    build_exp(); busy_len = 3; drive();
    run(300);
    want = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 4; k++) chk($sformatf("fair_gid%0d", k), gid_log[k], want[k]);

    // Wrap: pointer moved to 2 by req1, then req2 and req0 compete
    do_reset();
    add_msg(1, 1); build_exp(); busy_len = 2; drive();
    run(100);
    gid_log.delete();
    add_msg(2, 1); add_msg(0, 1); build_exp(); drive();
    run(200);
    chk("wrap_first", gid_log[0], 2);
    chk("wrap_second", gid_log[1], 0);

    // Randomized traffic with mid-message valid gaps and random frame lengths
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) repeat ($urandom_range(1, 4)) add_msg(i, $urandom_range(1, 3));
      build_exp(); gap_en = 1; drive();
      run(4000);
      chk($sformatf("rand%0d_empty", r), exp_q.size(), 0);
      chk($sformatf("rand%0d_consumed", r), pending(), 0);
      chk($sformatf("rand%0d_no_timeout", r), to_cnt, 0);
    end

    // Stalled owner: req0 stops after a non-last byte while req1 waits
    do_reset();
    busy_len = 10;
    add_byte(0, 8'hA5, 1'b0); add_byte(0, 8'h5A, 1'b1); add_byte(1, 8'hC3, 1'b1);
    exp_q.push_back({2'd0, 8'hA5});
`ifdef UART_ARB_TIMEOUT_EN
    exp_q.push_back({2'd1, 8'hC3});
`endif
    drive();
    n = 0;
    while (dp[0] == 0 && n < 10) begin step(); n++; end
    chk("stall_setup", dp[0], 1);
    stall[0] = 1; drive();
`ifdef UART_ARB_TIMEOUT_EN
    t = -1; n = 0;
    while (t < 0 && n < 60) begin step(); if (s_to) t = s_cyc; n++; end
    chk("timeout_cycle", t, 30);
    n = 0;
    while (!(s_gv && s_gid == 2'd1) && n < 5) begin step(); n++; end
    chk("timeout_regrant", {s_gv, s_gid}, 3'b101);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin step(); n++; end
    chk("timeout_req1_sent", exp_q.size(), 0);
    chk("timeout_pulses", to_cnt, 1);
`else
    t = 0;
    repeat (60) step();
    chk("hold_no_timeout", to_cnt, 0);
    chk("hold_grant", {s_gv, s_gid}, 3'b100);
    chk("hold_sent", exp_q.size(), 0);
`endif

    // Asynchronous reset while the frame is shifting
    do_reset();
    busy_len = 10;
    add_byte(1, 8'h3C, 1'b0); add_byte(1, 8'hE7, 1'b1);
    build_exp(); drive();
    repeat (6) step();
    chk("midrst_busy", tx_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 0);
    chk("midrst_start", tx_start, 0);
    chk("midrst_gv", grant_valid, 0);
    chk("midrst_gid", grant_id, 0);
    chk("midrst_data", tx_data, 0);
    do_reset();
    repeat (20) step();
    chk("midrst_no_start", start_cyc.size(), 0);
    chk("midrst_idle", s_gv, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
